// File: rtl/smg_scan_controller.sv
`default_nettype none
// ============================================================================
//  Module      : smg_scan_controller
//  Description : Time-multiplexed scan sequencer for a common-digit seven-
//                segment display with dead time, blanking and frame-aligned
//                display updates.
//  Revision    : 1.0 - initial release
// ============================================================================
module smg_scan_controller #(
    parameter int DIGITS       = 4,
    parameter int SHOW_CYCLES  = 5000,
    parameter int BLANK_CYCLES = 50,
    parameter int LZB_EN       = 1
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      upd_valid,
    input  logic [4*DIGITS-1:0]       upd_data,
    output logic                      upd_ready,
    output logic [3:0]                NumberData,
    output logic [DIGITS-1:0]         DigitSel,
    output logic [$clog2(DIGITS)-1:0] digit_idx,
    output logic                      frame_done
);

    localparam int c_IW   = $clog2(DIGITS);
    localparam int c_MAXC = (SHOW_CYCLES > BLANK_CYCLES) ? SHOW_CYCLES : BLANK_CYCLES;
    localparam int c_CW   = (c_MAXC > 1) ? $clog2(c_MAXC) : 1;

    localparam logic [c_CW-1:0] c_SHOW_LAST  = c_CW'(SHOW_CYCLES - 1);
    localparam logic [c_CW-1:0] c_BLANK_LAST = c_CW'(BLANK_CYCLES - 1);
    localparam logic [c_IW-1:0] c_LAST_IDX   = c_IW'(DIGITS - 1);

    typedef enum logic [0:0] {
        S_BLANK = 1'b0,
        S_SHOW  = 1'b1
    } state_t;

    state_t                r_state;
    state_t                w_stateNext;
    logic [c_CW-1:0]       r_cnt;
    logic [c_CW-1:0]       w_cntNext;
    logic [c_IW-1:0]       r_idx;
    logic [c_IW-1:0]       w_idxNext;
    logic                  w_frameDone;
    logic [4*DIGITS-1:0]   r_disp;
    logic [4*DIGITS-1:0]   w_dispNext;
    logic [4*DIGITS-1:0]   r_pendData;
    logic                  r_pend;
    logic [3:0]            r_num;
    logic [DIGITS-1:0]     r_sel;
    logic [DIGITS-1:0]     w_blank;
    logic                  w_zeroRun;
    logic [3:0]            w_nib;
    logic                  w_blkSel;
    logic [DIGITS-1:0]     w_oneHot;

    // Slot sequencing: the counter counts elapsed cycles within the phase.
    always_comb begin
        w_stateNext = r_state;
        w_cntNext   = r_cnt + c_CW'(1);
        w_idxNext   = r_idx;
        w_frameDone = 1'b0;
        case (r_state)
            S_BLANK: begin
                if (r_cnt == c_BLANK_LAST) begin
                    w_stateNext = S_SHOW;
                    w_cntNext   = '0;
                end
            end
            S_SHOW: begin
                if (r_cnt == c_SHOW_LAST) begin
                    w_stateNext = S_BLANK;
                    w_cntNext   = '0;
                    w_idxNext   = (r_idx == c_LAST_IDX) ? '0 : r_idx + c_IW'(1);
                    w_frameDone = (r_idx == c_LAST_IDX);
                end
            end
            default: w_stateNext = S_BLANK;
        endcase
    end

    // Everything for the upcoming slot is derived from the display value it will use,
    // so the first slot of a frame already sees a freshly applied update.
    always_comb begin
        w_dispNext = (w_frameDone && r_pend) ? r_pendData : r_disp;
        w_zeroRun  = 1'b1;
        w_blank    = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            w_zeroRun  = w_zeroRun & (w_dispNext[i*4 +: 4] == 4'h0);
            w_blank[i] = (w_dispNext[i*4 +: 4] > 4'd9) |
                         ((LZB_EN != 0) && (i != 0) && w_zeroRun);
        end
        w_nib    = 4'h0;
        w_blkSel = 1'b0;
        w_oneHot = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (w_idxNext == c_IW'(i)) begin
                w_nib       = w_dispNext[i*4 +: 4];
                w_blkSel    = w_blank[i];
                w_oneHot[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state    <= S_BLANK;
            r_cnt      <= '0;
            r_idx      <= '0;
            r_disp     <= {DIGITS{4'hF}};
            r_pendData <= '0;
            r_pend     <= 1'b0;
            r_num      <= 4'h0;
            r_sel      <= '1;
        end else begin
            r_state <= w_stateNext;
            r_cnt   <= w_cntNext;
            r_idx   <= w_idxNext;
            r_disp  <= w_dispNext;
            r_num   <= w_nib;
            r_sel   <= ((w_stateNext == S_SHOW) && !w_blkSel) ? ~w_oneHot : '1;
            // Apply and accept are mutually exclusive: accepting needs an empty buffer.
            if (w_frameDone && r_pend) begin
                r_pend <= 1'b0;
            end else if (upd_valid && !r_pend) begin
                r_pend     <= 1'b1;
                r_pendData <= upd_data;
            end
        end
    end

    assign upd_ready  = ~r_pend;
    assign NumberData = r_num;
    assign DigitSel   = r_sel;
    assign digit_idx  = r_idx;
    assign frame_done = w_frameDone;

endmodule
`default_nettype wire

// File: tb/tb_smg_scan_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_smg_scan_controller
//  Description : Directed self-checking bench for smg_scan_controller.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_smg_scan_controller;

    logic        CLK = 1'b0;
    logic        RST;
    logic        upd_valid;
    logic [15:0] upd_data;
    logic        upd_ready,  upd_ready0;
    logic [3:0]  NumberData, NumberData0;
    logic [3:0]  DigitSel,   DigitSel0;
    logic [1:0]  digit_idx,  digit_idx0;
    logic        frame_done, frame_done0;

    int nTests = 0;
    int nFail  = 0;

    always #5 CLK = ~CLK;

    smg_scan_controller #(
        .DIGITS(4), .SHOW_CYCLES(4), .BLANK_CYCLES(2), .LZB_EN(1)
    ) dut (
        .CLK(CLK), .RST(RST), .upd_valid(upd_valid), .upd_data(upd_data),
        .upd_ready(upd_ready), .NumberData(NumberData), .DigitSel(DigitSel),
        .digit_idx(digit_idx), .frame_done(frame_done)
    );

    smg_scan_controller #(
        .DIGITS(4), .SHOW_CYCLES(4), .BLANK_CYCLES(2), .LZB_EN(0)
    ) dutNoLzb (
        .CLK(CLK), .RST(RST), .upd_valid(upd_valid), .upd_data(upd_data),
        .upd_ready(upd_ready0), .NumberData(NumberData0), .DigitSel(DigitSel0),
        .digit_idx(digit_idx0), .frame_done(frame_done0)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nTests++;
        if (obs !== exp) begin
            nFail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit isBlank(input logic [15:0] v, input int slot, input bit lzb);
        logic [15:0] upper;
        upper = v >> (4 * slot);
        if (upper[3:0] > 4'd9) return 1'b1;
        if (lzb && slot != 0 && upper == 16'h0) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [3:0] expSel(input logic [15:0] v, input int p, input bit lzb);
        logic [3:0] one;
        one = 4'b0001;
        if ((p % 6) < 2 || isBlank(v, p / 6, lzb)) return 4'hF;
        return ~(one << (p / 6));
    endfunction

    // Starts and ends at a falling edge; p counts cycles from the frame's first BLANK cycle.
    task automatic runFrame(input logic [15:0] shown, input int len,
                            input int offAt, input int offN,
                            input logic [15:0] d0, input logic r0,
                            input logic [15:0] d1, input logic r1);
        logic [15:0] nibs;
        for (int p = 0; p < len; p++) begin
            upd_valid = 1'b0;
            upd_data  = 16'h0;
            if (offN >= 1 && p == offAt) begin
                upd_valid = 1'b1;
                upd_data  = d0;
                check($sformatf("ready0 p%0d", p), {31'b0, upd_ready}, {31'b0, r0});
            end else if (offN == 2 && p == offAt + 1) begin
                upd_valid = 1'b1;
                upd_data  = d1;
                check($sformatf("ready1 p%0d", p), {31'b0, upd_ready}, {31'b0, r1});
            end
            check($sformatf("sel %h p%0d", shown, p), {28'b0, DigitSel}, {28'b0, expSel(shown, p, 1'b1)});
            check($sformatf("selNoLzb %h p%0d", shown, p), {28'b0, DigitSel0}, {28'b0, expSel(shown, p, 1'b0)});
            check($sformatf("fdone p%0d", p), {31'b0, frame_done}, (p == 23) ? 32'd1 : 32'd0);
            if ((p % 6) >= 2) begin
                nibs = shown >> (4 * (p / 6));
                check($sformatf("num %h p%0d", shown, p), {28'b0, NumberData}, {28'b0, nibs[3:0]});
                check($sformatf("idx p%0d", p), {30'b0, digit_idx}, p / 6);
            end
            @(negedge CLK);
        end
        upd_valid = 1'b0;
    endtask

    task automatic checkReset(input string tag);
        check({tag, " sel"},   {28'b0, DigitSel},   32'hF);
        check({tag, " ready"}, {31'b0, upd_ready},  32'd1);
        check({tag, " fdone"}, {31'b0, frame_done}, 32'd0);
        check({tag, " num"},   {28'b0, NumberData}, 32'd0);
        check({tag, " idx"},   {30'b0, digit_idx},  32'd0);
    endtask

    initial begin
        RST       = 1'b1;
        upd_valid = 1'b0;
        upd_data  = 16'h0;
        repeat (3) @(negedge CLK);
        checkReset("rst");
        RST = 1'b0;

        runFrame(16'hFFFF, 24, -1, 0, 16'h0,    1'b0, 16'h0,    1'b0);
        runFrame(16'hFFFF, 24, -1, 0, 16'h0,    1'b0, 16'h0,    1'b0);
        runFrame(16'hFFFF, 24, 10, 1, 16'h1234, 1'b1, 16'h0,    1'b0);
        runFrame(16'h1234, 24,  5, 1, 16'h0070, 1'b1, 16'h0,    1'b0);
        runFrame(16'h0070, 24,  5, 1, 16'h0000, 1'b1, 16'h0,    1'b0);
        runFrame(16'h0000, 24,  8, 2, 16'h1111, 1'b1, 16'h2222, 1'b0);
        runFrame(16'h1111, 24,  3, 1, 16'h2222, 1'b1, 16'h0,    1'b0);
        runFrame(16'h2222, 24, 23, 1, 16'h5555, 1'b1, 16'h0,    1'b0);
        runFrame(16'h2222, 24, -1, 0, 16'h0,    1'b0, 16'h0,    1'b0);
        runFrame(16'h5555, 24, -1, 0, 16'h0,    1'b0, 16'h0,    1'b0);
        runFrame(16'h5555, 14,  2, 1, 16'h9999, 1'b1, 16'h0,    1'b0);

        // Now in SHOW of digit 2 with 9999 pending.
        check("midshow sel",   {28'b0, DigitSel},  32'hB);
        check("midshow ready", {31'b0, upd_ready}, 32'd0);
        RST = 1'b1;
        @(negedge CLK);
        checkReset("midrst");
        @(negedge CLK);
        RST = 1'b0;
        runFrame(16'hFFFF, 24, -1, 0, 16'h0, 1'b0, 16'h0, 1'b0);
        runFrame(16'hFFFF, 24, -1, 0, 16'h0, 1'b0, 16'h0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
`default_nettype wire
